alu_seq: RTL
============

# alu_seq

Multi-cycle sequencer that sits between the issue stage and the shared combinational ALU. It accepts one command at a time over a valid/ready handshake and drives the ALU's `s_config` and operands for one or more cycles. It returns a registered result and a compare code over a second valid/ready handshake. Supported command kinds are single-pass ALU operations, signed compare (subtract-based) and an iterative shift-add multiply.

## Interface
- `WIDTH`, 32: operand and result width; must be ≥ 2.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer can accept a command.
- `cmd_kind` in `e_seq_kind`: one of `SEQ_PASS`, `SEQ_CMP`, `SEQ_MUL`.
- `cmd_cfg` in `alu::s_config`: ALU configuration; used only for `SEQ_PASS`.
- `cmd_a`, `cmd_b` in WIDTH: operands.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_data` out WIDTH: result.
- `rsp_cmp` out `alu::e_cmp_res`: compare result.
- `rsp_err` out 1: unsupported command.
- `alu_cfg` out `alu::s_config`: configuration to the ALU.
- `alu_a`, `alu_b` out WIDTH: operands to the ALU.
- `alu_out` in WIDTH: combinational ALU result, sampled in the same cycle.

## Operation
- States: `IDLE`, `EXEC`, `MUL_ITER`, `DONE`.
- `cmd_ready` = (state == `IDLE`) && !`rst`. The command is accepted when `cmd_valid && cmd_ready`; the operands and kind are latched.
- **Transitions from `IDLE` on accept:**
  - `SEQ_PASS` or `SEQ_CMP` → `EXEC`.
  - `SEQ_MUL` with `cmd_b` ≠ 0 → `MUL_ITER`.
  - `SEQ_MUL` with `cmd_b` == 0 → `DONE` with `rsp_data` = 0.
- **`EXEC` (one cycle):**
  - `SEQ_PASS`: `alu_cfg` = latched `cmd_cfg`, `alu_a`/`alu_b` = latched operands. `rsp_data` ← `alu_out`. `rsp_cmp` = `CMP_RES_EQ`.
  - `SEQ_CMP`: `alu_cfg` = {op `CORE_OP_ADD`, `a_op` `UNARY_OP_ID`, `b_op` `UNARY_OP_NEG`, `b_shift` all-zero, `out_op` `UNARY_OP_ID`}.
    - `rsp_data` ← `alu_out` (a−b, modulo 2^WIDTH).
    - `rsp_cmp` = `CMP_RES_EQ` if `alu_out` == 0.
    - Otherwise `rsp_cmp` = `CMP_RES_LT` if signed a < b, else `CMP_RES_GT`.
    - Signed a < b = (a[MSB] ≠ b[MSB]) ? a[MSB] : `alu_out`[MSB].
  - `EXEC` → `DONE`.
- **`MUL_ITER`:** internal registers `acc` (reset to 0 on accept), `mcand` (= a) and `mplier` (= b).
  - Each cycle, `alu_cfg` = plain ADD with `b_shift` all-zero; `alu_a` = `acc`, `alu_b` = `mcand`.
  - If `mplier[0]`, then `acc` ← `alu_out`.
  - Then `mcand` ← `mcand` << 1 and `mplier` ← `mplier` >> 1.
  - Exit to `DONE` when the shifted `mplier` is 0.
  - `rsp_data` = `acc`: the low WIDTH bits of the product, identical for signed and unsigned operands. `rsp_cmp` = `CMP_RES_EQ`.
- **`DONE`:** `rsp_valid` = 1. It stays in `DONE`, holding all `rsp_*` stable, until `rsp_ready`; then → `IDLE`.
- **Outside `EXEC`/`MUL_ITER`:** `alu_cfg` = all-zero (ADD, ID, ID, no shift, ID) and `alu_a` = `alu_b` = 0.
- **Invalid `cmd_kind` encoding:** → `DONE` with `rsp_err` = 1 and `rsp_data` = 0.
- **Reset:** `rst` in any state forces `IDLE` and discards any in-flight command or undelivered response.
- **Reset values:** `rsp_valid` 0, `rsp_data` 0, `rsp_cmp` `CMP_RES_EQ`, `rsp_err` 0, `alu_*` 0, `cmd_ready` 0 while `rst` is high.

## Timing
- All outputs are registered except `cmd_ready`, which is decoded from state.
- Accept in cycle N:
  - `SEQ_PASS`/`SEQ_CMP`: `rsp_valid` rises at N+2.
  - `SEQ_MUL` with b = 0: `rsp_valid` rises at N+1.
  - `SEQ_MUL` with b ≠ 0: k = index of the highest set bit of b, plus 1. `rsp_valid` rises at N+1+k, so the maximum is N+1+WIDTH.
- Throughput: the next accept occurs no earlier than the cycle after the response handshake (`DONE` → `IDLE` → accept). No overlap.
- `rsp_ready` held high: one command per (latency + 1) cycles.
- `rsp_ready` low: `rsp_valid` and the data stay stable indefinitely, and `cmd_ready` stays 0.

## Configuration
- `ALU_SEQ_MUL_EN` defined: `SEQ_MUL` is supported as above.
- `ALU_SEQ_MUL_EN` undefined:
  - The `MUL_ITER` state, `acc`/`mcand`/`mplier` and the iteration logic are not compiled.
  - `SEQ_MUL` takes the invalid-kind path: `DONE` at N+1, `rsp_err` = 1, `rsp_data` = 0.

## Structure
- `e_seq_kind` {`SEQ_PASS`, `SEQ_CMP`, `SEQ_MUL`} and the state enum belong in shared package `alu_seq_pkg`.
- `alu_seq_pkg` also holds the constant `ALU_CFG_ADD` (plain-ADD `s_config`) and `ALU_CFG_SUB`. It imports `alu` and `common`.
- One sub-module, `alu_seq_mul`, holds the `acc`/`mcand`/`mplier` registers and the exit detect. It is instantiated only under `ALU_SEQ_MUL_EN`.
- The ALU itself is instantiated by the parent, not inside `alu_seq`.

## Test plan
- **PASS:** cfg = `CORE_OP_XOR`, a = 0xF0F0_0000, b = 0x0FF0_0000, `rsp_ready` = 1 → `rsp_data` = 0xFF00_0000 with `rsp_valid` at N+2.
- **CMP:**
  - a = 5, b = 5 → `CMP_RES_EQ`, data 0.
  - a = 0xFFFF_FFFF (−1), b = 1 → `CMP_RES_LT`.
  - a = 0x7FFF_FFFF, b = 0x8000_0000 → `CMP_RES_GT` (overflow case).
- **MUL:**
  - a = 7, b = 6 → data 42, `rsp_valid` at N+4.
  - a = 0xFFFF_FFFF, b = 0x8000_0000 → 0x8000_0000 at N+33.
  - b = 0 → data 0 at N+1.
- **Backpressure:** `rsp_ready` low for 5 cycles after `rsp_valid` → data stable, `cmd_ready` = 0, and the new `cmd_valid` is not accepted until the cycle after the handshake.
- **Reset mid-MUL:** `rst` asserted in the 3rd `MUL_ITER` cycle → next cycle `IDLE`, `rsp_valid` 0, `alu_*` 0, `cmd_ready` 1 after `rst` drops, with no stale response.
- **Macro off:** `SEQ_MUL` with a = 3, b = 4 → `rsp_err` = 1, data 0 at N+1. An invalid `cmd_kind` behaves the same in both builds.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer, plus the small common/alu packages it builds on.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiply state.

package common;

  localparam int unsigned MIN_WIDTH = 2;

endpackage

package alu;

  typedef enum logic [2:0] {
    CORE_OP_ADD = 3'd0,
    CORE_OP_AND = 3'd1,
    CORE_OP_OR  = 3'd2,
    CORE_OP_XOR = 3'd3
  } e_core_op;

  typedef enum logic [1:0] {
    UNARY_OP_ID  = 2'd0,
    UNARY_OP_NEG = 2'd1,
    UNARY_OP_NOT = 2'd2
  } e_unary_op;

  typedef enum logic [1:0] {
    CMP_RES_EQ = 2'd0,
    CMP_RES_LT = 2'd1,
    CMP_RES_GT = 2'd2
  } e_cmp_res;

  typedef struct packed {
    e_core_op   op;
    e_unary_op  a_op;
    e_unary_op  b_op;
    logic [4:0] b_shift;
    e_unary_op  out_op;
  } s_config;

endpackage

package alu_seq_pkg;

  import alu::*;
  import common::*;

  typedef enum logic [1:0] {
    SEQ_PASS = 2'd0,
    SEQ_CMP  = 2'd1,
    SEQ_MUL  = 2'd2
  } e_seq_kind;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StExec    = 2'd1,
`ifdef ALU_SEQ_MUL_EN
    StMulIter = 2'd3,
`endif
    StDone    = 2'd2
  } e_seq_state;

  localparam s_config ALU_CFG_ADD = '{
    op:      CORE_OP_ADD,
    a_op:    UNARY_OP_ID,
    b_op:    UNARY_OP_ID,
    b_shift: 5'd0,
    out_op:  UNARY_OP_ID
  };

  // a + (-b) gives a - b modulo 2^WIDTH on the shared adder.
  localparam s_config ALU_CFG_SUB = '{
    op:      CORE_OP_ADD,
    a_op:    UNARY_OP_ID,
    b_op:    UNARY_OP_NEG,
    b_shift: 5'd0,
    out_op:  UNARY_OP_ID
  };

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add multiply state for alu_seq: accumulator, shifted multiplicand and multiplier.
// Only instantiated when ALU_SEQ_MUL_EN is defined.

module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] acc_d,
  output logic [WIDTH-1:0] mcand_d,
  output logic             last
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] mplier_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
    end else if (step) begin
      if (mplier_q[0]) begin
        acc_d = alu_out;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  // Current step is the last one once no set bits remain above bit 0.
  assign last = (mplier_q[WIDTH-1:1] == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle command sequencer in front of the shared combinational ALU.
// ALU_SEQ_MUL_EN enables SEQ_MUL; without it SEQ_MUL is reported as unsupported.

module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  e_seq_kind           cmd_kind,
  input  alu::s_config        cmd_cfg,
  input  logic [WIDTH-1:0]    cmd_a,
  input  logic [WIDTH-1:0]    cmd_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WIDTH-1:0]    rsp_data,
  output alu::e_cmp_res       rsp_cmp,
  output logic                rsp_err,
  output alu::s_config        alu_cfg,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  input  logic [WIDTH-1:0]    alu_out
);

  e_seq_state state_q;
  e_seq_kind  kind_q;
  logic       accept;
  logic       cmp_lt;

  assign cmd_ready = (state_q == StIdle) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  // In EXEC the latched operands sit on alu_a/alu_b; equal signs defer to the difference sign.
  assign cmp_lt = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) ? alu_a[WIDTH-1] : alu_out[WIDTH-1];

`ifdef ALU_SEQ_MUL_EN
  logic             mul_start;
  logic             mul_step;
  logic             mul_last;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] mcand_d;

  assign mul_start = accept && (cmd_kind == SEQ_MUL) && (cmd_b != '0);
  assign mul_step  = (state_q == StMulIter);

  alu_seq_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .step    (mul_step),
    .a       (cmd_a),
    .b       (cmd_b),
    .alu_out (alu_out),
    .acc_d   (acc_d),
    .mcand_d (mcand_d),
    .last    (mul_last)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      kind_q    <= SEQ_PASS;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_cmp   <= alu::CMP_RES_EQ;
      rsp_err   <= 1'b0;
      alu_cfg   <= ALU_CFG_ADD;
      alu_a     <= '0;
      alu_b     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            kind_q   <= cmd_kind;
            rsp_data <= '0;
            rsp_cmp  <= alu::CMP_RES_EQ;
            rsp_err  <= 1'b0;
            case (cmd_kind)
              SEQ_PASS, SEQ_CMP: begin
                state_q <= StExec;
                alu_cfg <= (cmd_kind == SEQ_PASS) ? cmd_cfg : ALU_CFG_SUB;
                alu_a   <= cmd_a;
                alu_b   <= cmd_b;
              end
`ifdef ALU_SEQ_MUL_EN
              SEQ_MUL: begin
                if (cmd_b != '0) begin
                  // First iteration adds the multiplicand onto a cleared accumulator.
                  state_q <= StMulIter;
                  alu_cfg <= ALU_CFG_ADD;
                  alu_a   <= '0;
                  alu_b   <= cmd_a;
                end else begin
                  state_q   <= StDone;
                  rsp_valid <= 1'b1;
                end
              end
`endif
              default: begin
                state_q   <= StDone;
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
              end
            endcase
          end
        end
        StExec: begin
          rsp_data <= alu_out;
          if (kind_q == SEQ_CMP && alu_out != '0) begin
            rsp_cmp <= cmp_lt ? alu::CMP_RES_LT : alu::CMP_RES_GT;
          end
          alu_cfg   <= ALU_CFG_ADD;
          alu_a     <= '0;
          alu_b     <= '0;
          rsp_valid <= 1'b1;
          state_q   <= StDone;
        end
`ifdef ALU_SEQ_MUL_EN
        StMulIter: begin
          if (mul_last) begin
            rsp_data  <= acc_d;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_valid <= 1'b1;
            state_q   <= StDone;
          end else begin
            alu_a <= acc_d;
            alu_b <= mcand_d;
          end
        end
`endif
        StDone: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
